// File: rtl/menu_key_pkg.sv
// rtl/menu_key_pkg.sv - shared constants and types for the menu key conditioner
// Build option: MENU_KEY_REPEAT_EN enables auto-repeat while a key is held.
package menu_key_pkg;

    localparam int KEY_NUM   = 4;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_ENTER = 2;
    localparam int KEY_BACK  = 3;

    typedef logic [KEY_NUM-1:0] key_vec_t;

endpackage

// File: rtl/menu_key_ctl_if.sv
// rtl/menu_key_ctl_if.sv - key line bundle between the raw buttons, the conditioner and the menu
// Signals:
//   key_raw   raw asynchronous key lines (UP, DOWN, ENTER, BACK)
//   key_pulse one-cycle, at most one-hot, accepted press strobe
//   key_level debounced level of each key
//   key_busy  any press still waiting to be issued
// Modports: master drives key_raw and observes the rest; slave is the conditioner.
interface menu_key_ctl_if;
    import menu_key_pkg::*;

    key_vec_t key_raw;
    key_vec_t key_pulse;
    key_vec_t key_level;
    logic     key_busy;

    modport master (
        output key_raw,
        input  key_pulse,
        input  key_level,
        input  key_busy
    );

    modport slave (
        input  key_raw,
        output key_pulse,
        output key_level,
        output key_busy
    );

endinterface

// File: rtl/menu_key_ctl_debounce.sv
// rtl/menu_key_ctl_debounce.sv - one-key synchroniser, debouncer and optional auto-repeat timer
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   key_raw    raw asynchronous key line
//   key_level  debounced level (registered)
//   press      combinational request, high on the edge the level rises
//              (and, with MENU_KEY_REPEAT_EN, on each auto-repeat edge)
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 32500000,
    parameter int REPEAT_PERIOD   = 9750000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject illegal configurations at elaboration.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_repeat
        $error("need REPEAT_DELAY >= REPEAT_PERIOD >= 1");
    end

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             rise;

`ifdef MENU_KEY_REPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(REPEAT_DELAY - 1);
    // Reloading to DELAY-PERIOD makes the next wrap exactly PERIOD cycles later.
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              fire;
`endif

    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;

        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        rise = level_d & ~level_q;

`ifdef MENU_KEY_REPEAT_EN
        // Counter runs only across edges where the key stays held.
        hold_d = hold_q;
        fire   = 1'b0;
        if (!level_q || !level_d) begin
            hold_d = '0;
        end else if (hold_q == HOLD_MAX) begin
            fire   = 1'b1;
            hold_d = HOLD_RELOAD;
        end else begin
            hold_d = hold_q + 1'b1;
        end
        press = rise | fire;
`else
        press = rise;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
`ifdef MENU_KEY_REPEAT_EN
            hold_q  <= '0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
`ifdef MENU_KEY_REPEAT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign key_level = level_q;

endmodule

// File: rtl/menu_key_ctl.sv
// rtl/menu_key_ctl.sv - conditions four raw keys into serialised one-cycle strobes for the menu
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   kif       menu_key_ctl_if.slave: key_raw in; key_pulse, key_level, key_busy out
// Build option: MENU_KEY_REPEAT_EN adds auto-repeat while a key is held.
module menu_key_ctl
    import menu_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 32500000,
    parameter int REPEAT_PERIOD   = 9750000
) (
    input  logic          clk,
    input  logic          rst,
    menu_key_ctl_if.slave kif
);

    key_vec_t level;
    key_vec_t press;
    key_vec_t grant;
    key_vec_t pending_q, pending_d;
    key_vec_t pulse_q,   pulse_d;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_debounce (
            .clk       (clk),
            .rst       (rst),
            .key_raw   (kif.key_raw[i]),
            .key_level (level[i]),
            .press     (press[i])
        );
    end

    always_comb begin
        // Isolate the lowest set bit: fixed priority UP > DOWN > ENTER > BACK.
        grant     = pending_q & key_vec_t'(~pending_q + 1'b1);
        pulse_d   = grant;
        // New presses are OR-ed after the clear so a press landing on its own
        // service edge stays pending; repeated presses on a set bit merge.
        pending_d = (pending_q & ~grant) | press;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            pulse_q   <= '0;
        end else begin
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
        end
    end

    assign kif.key_pulse = pulse_q;
    assign kif.key_level = level;
    assign kif.key_busy  = |pending_q;

endmodule

// File: tb/tb_menu_key_ctl.sv
// tb/tb_menu_key_ctl.sv - scoreboard bench for menu_key_ctl with short debounce/repeat timing
module tb_menu_key_ctl;
    import menu_key_pkg::*;

    typedef struct {
        key_vec_t pulse;
        int       cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    menu_key_ctl_if kif();

    menu_key_ctl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push(input key_vec_t p, input int c);
        exp_t e;
        e.pulse = p;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every non-zero strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && kif.key_pulse != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse act=%b exp=none (cyc %0d)", kif.key_pulse, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (kif.key_pulse !== e.pulse || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse act=%b@%0d exp=%b@%0d", kif.key_pulse, cyc, e.pulse, e.cyc);
                end
            end
        end
    end

    initial begin
        int n;
        kif.key_raw = 4'hF;

        // Reset hold with all keys asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_pulse", int'(kif.key_pulse), 0);
            chk("rst_level", int'(kif.key_level), 0);
            chk("rst_busy",  int'(kif.key_busy),  0);
        end
        kif.key_raw = 4'h0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_pulse", int'(kif.key_pulse), 0);
        wait_until(cyc + 8);

        // Clean press on UP: level rises at n+6, pulse at n+7.
        n = cyc;
        kif.key_raw = 4'b0001;
        push(4'b0001, n + 7);
        wait_until(n + 5);
        chk("up_level_before", int'(kif.key_level), 0);
        wait_until(n + 6);
        chk("up_level_rise", int'(kif.key_level), 1);
        chk("up_busy", int'(kif.key_busy), 1);
        wait_until(n + 8);
        chk("up_busy_after", int'(kif.key_busy), 0);
        wait_until(n + 16);
        kif.key_raw = 4'b0000;
        wait_until(n + 30);
        chk("up_level_release", int'(kif.key_level), 0);

        // Bounce on DOWN: 2-cycle pulses never reach the debounce limit.
        n = cyc;
        kif.key_raw = 4'b0010;
        wait_until(n + 2); kif.key_raw = 4'b0000;
        wait_until(n + 4); kif.key_raw = 4'b0010;
        wait_until(n + 6); kif.key_raw = 4'b0000;
        wait_until(n + 8);
        chk("bounce_level_mid", int'(kif.key_level), 0);
        wait_until(n + 20);
        chk("bounce_level_end", int'(kif.key_level), 0);

        // Simultaneous DOWN+ENTER: serialised, lower index first.
        n = cyc;
        kif.key_raw = 4'b0110;
        push(4'b0010, n + 7);
        push(4'b0100, n + 8);
        wait_until(n + 7);
        chk("simul_busy_first", int'(kif.key_busy), 1);
        wait_until(n + 8);
        chk("simul_busy_second", int'(kif.key_busy), 0);
        chk("simul_level", int'(kif.key_level), 6);
        kif.key_raw = 4'b0000;
        wait_until(n + 24);

        // Reset right after BACK's press becomes pending: press discarded.
        n = cyc;
        kif.key_raw = 4'b1000;
        wait_until(n + 6);
        chk("mid_busy_pending", int'(kif.key_busy), 1);
        rst = 1'b1;
        kif.key_raw = 4'b0000;
        wait_until(n + 8);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_pulse_after_rst", int'(kif.key_pulse), 0);
        chk("mid_busy_after_rst", int'(kif.key_busy), 0);
        chk("mid_level_after_rst", int'(kif.key_level), 0);
        wait_until(n + 24);

        // ENTER held 40 cycles.
        n = cyc;
        kif.key_raw = 4'b0100;
        push(4'b0100, n + 7);
`ifdef MENU_KEY_REPEAT_EN
        push(4'b0100, n + 27);
        push(4'b0100, n + 35);
        push(4'b0100, n + 43);
`endif
        wait_until(n + 40);
        chk("hold_level", int'(kif.key_level), 4);
        kif.key_raw = 4'b0000;
        wait_until(n + 70);
        chk("hold_level_release", int'(kif.key_level), 0);
        chk("hold_busy_end", int'(kif.key_busy), 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
